// File: rtl/line_delay_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// line_delay_ctrl_pkg : shared widths and FSM state encoding  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package line_delay_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/line_delay_ctrl_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter : enabled up-counter that wraps to 0 after a runtime limit  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wrap_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == limit) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/line_delay_ctrl.sv
// ---------------------------------------------------------------------------
// line_delay_ctrl : L-sample delay line over an external read-before-write
// single-port RAM (one sliding-window line buffer row)  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module line_delay_ctrl
  import line_delay_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;

  // Any write replaces ram_q, so a held output must block new input.
  assign in_ready = !reset && !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign ram_we    = accept;
  assign ram_addr  = wr_ptr;
  assign ram_data  = in_data;
  assign out_data  = ram_q;
  assign out_valid = out_valid_q;

  wrap_counter #(
    .W (ADDR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .en    (accept),
    .limit (len_q),
    .count (wr_ptr)
  );

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      state_d     = ST_FILL;
      fill_cnt_d  = '0;
      out_valid_d = 1'b0;
      len_d       = cfg_len;
    end else begin
      if (accept && (state_q == ST_RUN)) begin
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      // Read data from FILL writes is stale RAM content and is never emitted.
      if (accept && (state_q == ST_FILL)) begin
        fill_cnt_d = fill_cnt_q + ADDR_W'(1);
        if (fill_cnt_q == len_q) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= '0;
      len_q       <= '1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_delay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_delay_ctrl : directed self-checking bench with single-port RAM model  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_line_delay_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [5:0] cfg_len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;

  logic [7:0] mem [64];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Read-before-write single-port RAM; q only moves on a write cycle.
  always @(posedge clk) begin
    if (ram_we) begin
      ram_q         <= mem[ram_addr];
      mem[ram_addr] <= ram_data;
    end
  end

  line_delay_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [5:0] cfg);
    clear    = 1'b1;
    cfg_len  = cfg;
    in_valid = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic feed(input int first, input int last);
    for (int v = first; v <= last; v++) begin
      in_valid  = 1'b1;
      in_data   = 8'(v);
      out_ready = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; cfg_len = 6'd0;
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    tick();
    #1;
    total++;
    if ({in_ready, ram_we, out_valid, ram_addr} !== {1'b0, 1'b0, 1'b0, 6'd0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b we=%b ov=%b addr=%0d exp 0 0 0 0",
               in_ready, ram_we, out_valid, ram_addr);
    end
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got %b exp 1", in_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    do_clear(6'd3);
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      total++;
      if ({in_ready, ram_we, ram_addr, ram_data} !== {1'b1, 1'b1, 6'((i - 1) % 4), 8'(i)}) begin
        bad++;
        $display("FAIL basic_wr i=%0d got rdy=%b we=%b addr=%0d d=%0d exp 1 1 %0d %0d",
                 i, in_ready, ram_we, ram_addr, ram_data, (i - 1) % 4, i);
      end
      total++;
      if (out_valid !== (i == 6) || (i == 6 && out_data !== 8'd1)) begin
        bad++;
        $display("FAIL basic_out i=%0d got ov=%b d=%0d exp ov=%b d=1",
                 i, out_valid, out_data, (i == 6));
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd2) begin
      bad++;
      $display("FAIL basic_second got ov=%b d=%0d exp ov=1 d=2", out_valid, out_data);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain got ov=%b exp 0", out_valid);
    end
  endtask

  task automatic test_len1();
    logic [7:0] vals [3];
    vals[0] = 8'd10; vals[1] = 8'd11; vals[2] = 8'd12;
    do_clear(6'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      #1;
      total++;
      if (out_valid !== (i == 2) || (i == 2 && out_data !== 8'd10)) begin
        bad++;
        $display("FAIL len1_out i=%0d got ov=%b d=%0d exp ov=%b d=10",
                 i, out_valid, out_data, (i == 2));
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd11) begin
      bad++;
      $display("FAIL len1_second got ov=%b d=%0d exp ov=1 d=11", out_valid, out_data);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL len1_drain got ov=%b exp 0", out_valid);
    end
  endtask

  task automatic test_stall();
    do_clear(6'd3);
    feed(1, 5);
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd6;
      #1;
      total++;
      if ({in_ready, ram_we, out_valid, out_data} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin
        bad++;
        $display("FAIL stall_hold c=%0d got rdy=%b we=%b ov=%b d=%0d exp 0 0 1 1",
                 c, in_ready, ram_we, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 6; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      total++;
      if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 8'(i - 5)}) begin
        bad++;
        $display("FAIL stall_resume i=%0d got rdy=%b ov=%b d=%0d exp 1 1 %0d",
                 i, in_ready, out_valid, out_data, i - 5);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd4) begin
      bad++;
      $display("FAIL stall_tail got ov=%b d=%0d exp ov=1 d=4", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_wrap64();
    do_clear(6'd63);
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      total++;
      if (ram_addr !== 6'(i % 64)) begin
        bad++;
        $display("FAIL wrap_addr i=%0d got %0d exp %0d", i, ram_addr, i % 64);
      end
      total++;
      if (out_valid !== (i >= 65) || (i >= 65 && out_data !== 8'(i - 65))) begin
        bad++;
        $display("FAIL wrap_out i=%0d got ov=%b d=%0d exp ov=%b d=%0d",
                 i, out_valid, out_data, (i >= 65), i - 65);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd135) begin
      bad++;
      $display("FAIL wrap_tail got ov=%b d=%0d exp ov=1 d=135", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_clear_mid();
    logic [7:0] vals [3];
    vals[0] = 8'd7; vals[1] = 8'd8; vals[2] = 8'd9;
    do_clear(6'd3);
    feed(1, 5);
    clear = 1'b1; cfg_len = 6'd1; in_valid = 1'b1; in_data = 8'd99; out_ready = 1'b0;
    #1;
    total++;
    if ({in_ready, ram_we, out_valid} !== {1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL clear_cycle got rdy=%b we=%b ov=%b exp 0 0 1", in_ready, ram_we, out_valid);
    end
    tick();
    clear = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, ram_addr} !== {1'b0, 6'd0}) begin
      bad++;
      $display("FAIL clear_after got ov=%b addr=%0d exp 0 0", out_valid, ram_addr);
    end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      #1;
      total++;
      if ({out_valid, ram_addr} !== {1'b0, 6'(i % 2)}) begin
        bad++;
        $display("FAIL clear_refill i=%0d got ov=%b addr=%0d exp 0 %0d",
                 i, out_valid, ram_addr, i % 2);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd7) begin
      bad++;
      $display("FAIL clear_first_out got ov=%b d=%0d exp ov=1 d=7", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_clear(6'd3);
    feed(1, 5);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'd77; out_ready = 1'b1;
    #1;
    total++;
    if ({in_ready, ram_we} !== {1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_cycle got rdy=%b we=%b exp 0 0", in_ready, ram_we);
    end
    tick();
    reset = 1'b0; in_valid = 1'b0; cfg_len = 6'd0;
    #1;
    total++;
    if ({out_valid, ram_addr} !== {1'b0, 6'd0}) begin
      bad++;
      $display("FAIL rstmid_after got ov=%b addr=%0d exp 0 0", out_valid, ram_addr);
    end
    tick();
    for (int i = 0; i <= 64; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 50);
      #1;
      total++;
      if ({out_valid, ram_addr} !== {1'b0, 6'(i % 64)}) begin
        bad++;
        $display("FAIL rstmid_fill i=%0d got ov=%b addr=%0d exp 0 %0d",
                 i, out_valid, ram_addr, i % 64);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd50) begin
      bad++;
      $display("FAIL rstmid_first_out got ov=%b d=%0d exp ov=1 d=50", out_valid, out_data);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_drain got ov=%b exp 0", out_valid);
    end
  endtask

  initial begin
    ram_q = 8'd0;
    for (int a = 0; a < 64; a++) mem[a] = 8'd0;
    test_reset();
    test_basic();
    test_len1();
    test_stall();
    test_wrap64();
    test_clear_mid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_delay_ctrl.md
# line_delay_ctrl

Line-delay controller for the convolution datapath. It accepts a valid/ready pixel stream, writes each accepted sample into an external 64x8 single-port RAM at a circular address, and uses the RAM's read-before-write data to emit the sample accepted exactly L accepts earlier. The result is an L-sample delay line, one row of the sliding-window line buffer. It sits directly upstream of the single-port RAM instance and drives that RAM's data, address and write-enable ports.

## Interface
- DATA_W, 8, sample width
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W = 64
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous restart; also latches cfg_len
- cfg_len  in  ADDR_W  line length minus 1 (L = cfg_len+1, 1..64)
- in_valid  in  1  input sample valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_data  in  DATA_W  input sample
- out_valid  out  1  delayed sample valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  delayed sample
- ram_data  out  DATA_W  RAM write data
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_q  in  DATA_W  RAM read data: the previous contents of ram_addr, registered, updated only in the cycle after a ram_we=1 cycle, held otherwise

## Operation
- Registers: state {FILL, RUN}, wr_ptr[ADDR_W], fill_cnt[ADDR_W], len_q[ADDR_W], out_valid.
- accept = in_valid && in_ready. ram_we = accept, ram_addr = wr_ptr, ram_data = in_data (all combinational).
- in_ready = !reset && !clear && (!out_valid || out_ready). This is a combinational out_ready -> in_ready path; it is intentional and required, because a new write overwrites ram_q.
- out_data = ram_q, passed straight through with no register.
- On accept: wr_ptr <= (wr_ptr == len_q) ? 0 : wr_ptr+1.
- FILL: on accept, fill_cnt++. When accept occurs with fill_cnt == len_q, move to RUN. ram_q from FILL writes is garbage and is never marked valid.
- RUN: on accept, out_valid <= 1 next cycle. Stay in RUN until clear or reset.
- out_valid update: set on a RUN accept. Otherwise cleared when out_ready is high. A simultaneous out_ready and accept keeps out_valid = 1 with the new sample.
- clear (priority over everything except reset): in_ready forced to 0, so no write. Next cycle: state = FILL, wr_ptr = 0, fill_cnt = 0, out_valid = 0, len_q = cfg_len. Any pending out_valid sample is discarded.
- reset: same as clear, except len_q = DEPTH-1.
- cfg_len changes outside clear/reset are ignored.

## Timing
- Reset values: out_valid = 0, in_ready = 0 during reset, ram_we = 0, ram_addr = 0 (wr_ptr = 0), state = FILL.
- Latency: sample k accepted in cycle t is presented on out_data with out_valid = 1 in the cycle after the accept of sample k+L.
- Throughput: one sample per cycle while out_ready is held high.
- Stall: while out_valid && !out_ready, no write occurs, so ram_q and out_data hold stable.
- L = 1: the first accept enters RUN, and the second accept yields sample 0.
- L = 64: wr_ptr wraps naturally from 63 to 0.
- clear in the same cycle as in_valid: the sample is not accepted, because in_ready = 0.

## Structure
- Shared package holds: DATA_W/ADDR_W defaults and the state enum {ST_FILL, ST_RUN}.
- Sub-module: wrap_counter (ADDR_W-bit, enable, sync clear, runtime wrap limit), instantiated for wr_ptr. fill_cnt stays inline.
- RAM is external and not instantiated inside this block.
- The bench pairs the block with the team's single-port RAM model.

## Test plan
- Reset, cfg_len = 3, clear, feed 1,2,3,4,5,6 back-to-back with out_ready = 1 -> out_valid rises after the 5th accept; out_data = 1 then 2.
- cfg_len = 0 (L = 1), feed 10,11,12 -> outputs 10 then 11, each one cycle after the next accept.
- L = 4 in RUN, drop out_ready for 3 cycles with in_valid = 1 -> in_ready = 0 and out_data held constant; on release, the sequence resumes with no loss or duplicate.
- L = 64, stream 0..199 -> ram_addr wraps 63 -> 0; output n equals input n-64 for all outputs.
- Mid-RUN clear with cfg_len = 1 while out_valid = 1 -> next cycle out_valid = 0, wr_ptr = 0, FILL. New stream 7,8,9 -> first output 7 after the 3rd accept.
- Reset asserted mid-stream with in_valid = 1 -> ram_we = 0 that cycle; afterwards len_q = 63, and the first out_valid appears only after 64 fresh accepts.
